// File: rtl/ball_motion_sched.sv
// Frame-synchronous scheduler that steps each ball through one shared
// bounce/step datapath, two cycles per ball, once every FRAME_DIV accepted ticks.
module ball_motion_sched #(
  parameter int NUM_BALLS = 4,
  parameter int X_MIN     = 30,
  parameter int X_MAX     = 610,
  parameter int Y_MIN     = 30,
  parameter int Y_MAX     = 450,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     run,
  output logic [10*NUM_BALLS-1:0]  obj_x,
  output logic [10*NUM_BALLS-1:0]  obj_y,
  output logic [2*NUM_BALLS-1:0]   color_idx,
  output logic                     busy,
  output logic                     update_done,
  output logic                     overrun
);

  localparam logic [1:0] IDX_LAST = 2'(NUM_BALLS - 1);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] div_reg;
  logic [1:0] idx_reg;
  logic       overrun_reg;
  logic       accept, trigger;

  logic [9:0] x_reg   [NUM_BALLS];
  logic [9:0] y_reg   [NUM_BALLS];
  logic [1:0] dir_reg [NUM_BALLS];
  logic [1:0] col_reg [NUM_BALLS];

  logic [9:0] hold_x_reg, hold_y_reg;
  logic [1:0] hold_dir_reg;
  logic       hold_flip_reg;

  logic [9:0] cur_x, cur_y, nxt_x, nxt_y;
  logic [1:0] cur_dir, nxt_dir;
  logic       minus_x, plus_y, flip_x, flip_y, nminus_x, nplus_y;

  assign accept  = frame_start && run && (state_reg == IDLE);
  assign trigger = accept && (div_reg == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trigger) state_next = CALC;
      CALC:    state_next = WRITE;
      WRITE:   state_next = (idx_reg == IDX_LAST) ? DONE : CALC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_reg != IDLE);
    update_done = (state_reg == DONE);
  end

  assign overrun = overrun_reg;

  // Read mux for the ball currently being processed.
  always_comb begin
    cur_x   = '0;
    cur_y   = '0;
    cur_dir = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (idx_reg == 2'(i)) begin
        cur_x   = x_reg[i];
        cur_y   = y_reg[i];
        cur_dir = dir_reg[i];
      end
    end
  end

  // Bit1 of dir selects -x; bit0^bit1 selects +y. Axes reflect independently.
  always_comb begin
    minus_x  = cur_dir[1];
    plus_y   = cur_dir[0] ^ cur_dir[1];
    flip_x   = minus_x ? (cur_x <= 10'(X_MIN)) : (cur_x >= 10'(X_MAX));
    flip_y   = plus_y  ? (cur_y >= 10'(Y_MAX)) : (cur_y <= 10'(Y_MIN));
    nminus_x = minus_x ^ flip_x;
    nplus_y  = plus_y ^ flip_y;
    nxt_dir  = {nminus_x, nplus_y ^ nminus_x};
    nxt_x    = nminus_x ? (cur_x - 10'(STEP)) : (cur_x + 10'(STEP));
    nxt_y    = nplus_y  ? (cur_y + 10'(STEP)) : (cur_y - 10'(STEP));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg       <= '0;
      idx_reg       <= '0;
      overrun_reg   <= 1'b0;
      hold_x_reg    <= '0;
      hold_y_reg    <= '0;
      hold_dir_reg  <= '0;
      hold_flip_reg <= 1'b0;
    end else begin
      if (accept) div_reg <= trigger ? 8'd0 : div_reg + 8'd1;
      if (frame_start && (state_reg != IDLE)) overrun_reg <= 1'b1;
      if (state_reg == IDLE && trigger) idx_reg <= '0;
      else if (state_reg == WRITE && idx_reg != IDX_LAST) idx_reg <= idx_reg + 2'd1;
      if (state_reg == CALC) begin
        hold_x_reg    <= nxt_x;
        hold_y_reg    <= nxt_y;
        hold_dir_reg  <= nxt_dir;
        hold_flip_reg <= flip_x | flip_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        x_reg[i]   <= 10'(150 + 100 * i);
        y_reg[i]   <= 10'(400 - 80 * i);
        dir_reg[i] <= 2'(i);
        col_reg[i] <= 2'(i);
      end
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (state_reg == WRITE && idx_reg == 2'(i)) begin
          x_reg[i]   <= hold_x_reg;
          y_reg[i]   <= hold_y_reg;
          dir_reg[i] <= hold_dir_reg;
          col_reg[i] <= col_reg[i] + {1'b0, hold_flip_reg};
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_pack
      assign obj_x[10*gi +: 10]    = x_reg[gi];
      assign obj_y[10*gi +: 10]    = y_reg[gi];
      assign color_idx[2*gi +: 2]  = col_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_ball_motion_sched.sv
// Bench for ball_motion_sched: four differently parameterised instances checked
// against a per-ball velocity model, directed vectors and timing sequences.
module tb_ball_motion_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [3:0] fs  = 4'b0;

  always #5 clk = ~clk;

  logic [39:0] d_x, d_y;  logic [7:0] d_c;  logic d_busy, d_done, d_ovr;
  logic [9:0]  x_x, x_y;  logic [1:0] x_c;  logic x_busy, x_done, x_ovr;
  logic [9:0]  c_x, c_y;  logic [1:0] c_c;  logic c_busy, c_done, c_ovr;
  logic [19:0] v_x, v_y;  logic [3:0] v_c;  logic v_busy, v_done, v_ovr;

  ball_motion_sched u_def (
    .clk(clk), .rst(rst), .frame_start(fs[0]), .run(run),
    .obj_x(d_x), .obj_y(d_y), .color_idx(d_c),
    .busy(d_busy), .update_done(d_done), .overrun(d_ovr));

  ball_motion_sched #(.NUM_BALLS(1), .X_MAX(152)) u_xb (
    .clk(clk), .rst(rst), .frame_start(fs[1]), .run(run),
    .obj_x(x_x), .obj_y(x_y), .color_idx(x_c),
    .busy(x_busy), .update_done(x_done), .overrun(x_ovr));

  ball_motion_sched #(.NUM_BALLS(1), .X_MAX(151), .Y_MIN(399)) u_cor (
    .clk(clk), .rst(rst), .frame_start(fs[2]), .run(run),
    .obj_x(c_x), .obj_y(c_y), .color_idx(c_c),
    .busy(c_busy), .update_done(c_done), .overrun(c_ovr));

  ball_motion_sched #(.NUM_BALLS(2), .STEP(7), .FRAME_DIV(3)) u_div (
    .clk(clk), .rst(rst), .frame_start(fs[3]), .run(run),
    .obj_x(v_x), .obj_y(v_y), .color_idx(v_c),
    .busy(v_busy), .update_done(v_done), .overrun(v_ovr));

  int n_pass  = 0;
  int n_total = 0;

  // Model: per instance k, ball b, position plus signed velocity.
  int nb  [4] = '{4, 1, 1, 2};
  int xmn [4] = '{30, 30, 30, 30};
  int xmx [4] = '{610, 152, 151, 610};
  int ymn [4] = '{30, 30, 399, 30};
  int ymx [4] = '{450, 450, 450, 450};
  int stp [4] = '{1, 1, 1, 7};
  int fdv [4] = '{1, 1, 1, 3};
  int mx [4][4], my [4][4], mdx [4][4], mdy [4][4], mc [4][4];
  int mdiv [4];
  int movr [4];

  typedef struct {
    bit r;
    int d_x0, d_y0, xb_x, xb_c, cor_x, cor_y, cor_c, div_x0;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mdiv[k] = 0;
      movr[k] = 0;
      for (int b = 0; b < 4; b++) begin
        mx[k][b]  = 150 + 100 * b;
        my[k][b]  = 400 - 80 * b;
        mdx[k][b] = (b >= 2) ? -1 : 1;
        mdy[k][b] = (b == 1 || b == 2) ? 1 : -1;
        mc[k][b]  = b;
      end
    end
  endtask

  task automatic model_frame(input int k);
    int f;
    mdiv[k]++;
    if (mdiv[k] == fdv[k]) begin
      mdiv[k] = 0;
      for (int b = 0; b < nb[k]; b++) begin
        f = 0;
        if ((mdx[k][b] > 0 && mx[k][b] >= xmx[k]) || (mdx[k][b] < 0 && mx[k][b] <= xmn[k])) begin
          mdx[k][b] = -mdx[k][b]; f = 1;
        end
        if ((mdy[k][b] > 0 && my[k][b] >= ymx[k]) || (mdy[k][b] < 0 && my[k][b] <= ymn[k])) begin
          mdy[k][b] = -mdy[k][b]; f = 1;
        end
        mx[k][b] = mx[k][b] + mdx[k][b] * stp[k];
        my[k][b] = my[k][b] + mdy[k][b] * stp[k];
        mc[k][b] = (mc[k][b] + f) % 4;
      end
    end
  endtask

  function automatic int gx(input int k, input int b);
    case (k)
      0:       return int'(d_x[10*b +: 10]);
      1:       return int'(x_x);
      2:       return int'(c_x);
      default: return int'(v_x[10*b +: 10]);
    endcase
  endfunction

  function automatic int gy(input int k, input int b);
    case (k)
      0:       return int'(d_y[10*b +: 10]);
      1:       return int'(x_y);
      2:       return int'(c_y);
      default: return int'(v_y[10*b +: 10]);
    endcase
  endfunction

  function automatic int gc(input int k, input int b);
    case (k)
      0:       return int'(d_c[2*b +: 2]);
      1:       return int'(x_c);
      2:       return int'(c_c);
      default: return int'(v_c[2*b +: 2]);
    endcase
  endfunction

  function automatic int gflags(input int k);
    case (k)
      0:       return {d_busy, d_done, d_ovr};
      1:       return {x_busy, x_done, x_ovr};
      2:       return {c_busy, c_done, c_ovr};
      default: return {v_busy, v_done, v_ovr};
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < nb[k]; b++) begin
        chk($sformatf("%s i%0d b%0d x", tag, k, b), gx(k, b), mx[k][b]);
        chk($sformatf("%s i%0d b%0d y", tag, k, b), gy(k, b), my[k][b]);
        chk($sformatf("%s i%0d b%0d col", tag, k, b), gc(k, b), mc[k][b]);
      end
      chk($sformatf("%s i%0d busy/done/ovr", tag, k), gflags(k), movr[k]);
    end
  endtask

  task automatic apply_frame(input bit r, input logic [3:0] mask);
    @(negedge clk);
    run = r;
    fs  = mask;
    @(negedge clk);
    fs  = 4'b0;
    if (r) for (int k = 0; k < 4; k++) if (mask[k]) model_frame(k);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at;
    vecs[0] = '{1'b1, 151, 399, 151, 0, 151, 399, 0, 150};
    vecs[1] = '{1'b0, 151, 399, 151, 0, 151, 399, 0, 150};
    vecs[2] = '{1'b1, 152, 398, 152, 0, 150, 400, 1, 150};
    vecs[3] = '{1'b1, 153, 397, 151, 1, 149, 401, 1, 157};
    vecs[4] = '{1'b0, 153, 397, 151, 1, 149, 401, 1, 157};
    vecs[5] = '{1'b1, 154, 396, 150, 1, 148, 402, 1, 157};

    // Reset defaults
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst ball0 x", int'(d_x[9:0]), 150);
    chk("rst ball0 y", int'(d_y[9:0]), 400);
    chk("rst ball3 x", int'(d_x[39:30]), 450);
    chk("rst ball3 y", int'(d_y[39:30]), 160);
    chk("rst color packed", int'(d_c), 8'b11100100);
    chk("rst busy/done/ovr", int'({d_busy, d_done, d_ovr}), 0);
    rst = 1'b1;
    model_reset();
    check_all("reset");

    // Directed vectors: bounce, corner, run gating and divider
    for (int i = 0; i < 6; i++) begin
      apply_frame(vecs[i].r, 4'b1111);
      chk($sformatf("vec%0d def x0", i), int'(d_x[9:0]), vecs[i].d_x0);
      chk($sformatf("vec%0d def y0", i), int'(d_y[9:0]), vecs[i].d_y0);
      chk($sformatf("vec%0d xb x", i), int'(x_x), vecs[i].xb_x);
      chk($sformatf("vec%0d xb col", i), int'(x_c), vecs[i].xb_c);
      chk($sformatf("vec%0d cor x", i), int'(c_x), vecs[i].cor_x);
      chk($sformatf("vec%0d cor y", i), int'(c_y), vecs[i].cor_y);
      chk($sformatf("vec%0d cor col", i), int'(c_c), vecs[i].cor_c);
      chk($sformatf("vec%0d div x0", i), int'(v_x[9:0]), vecs[i].div_x0);
      check_all($sformatf("vec%0d", i));
    end

    // First-frame timing from reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    run = 1'b1;
    fs  = 4'b1111;
    @(negedge clk);
    fs  = 4'b0;
    for (int k = 0; k < 4; k++) model_frame(k);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    // Sample k lies between edge E0+k and E0+k+1.
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (d_busy) busy_cnt++;
      if (d_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 1) chk("t ball0 before commit", int'(d_x[9:0]), 150);
      if (k == 2) chk("t ball0 after commit", int'(d_x[9:0]), 151);
      if (k == 7) chk("t ball3 before commit", int'(d_x[39:30]), 450);
      if (k == 8) chk("t ball3 after commit", int'(d_x[39:30]), 449);
    end
    chk("t busy cycles", busy_cnt, 9);
    chk("t done pulses", done_cnt, 1);
    chk("t done position", done_at, 8);
    chk("t ball1 x", int'(d_x[19:10]), 251);
    chk("t ball1 y", int'(d_y[19:10]), 321);
    chk("t ball2 x", int'(d_x[29:20]), 349);
    chk("t ball2 y", int'(d_y[29:20]), 241);
    chk("t ball3 y", int'(d_y[39:30]), 159);
    check_all("timing");

    // frame_start while busy: overrun, no extra update
    @(negedge clk);
    run = 1'b1;
    fs  = 4'b0001;
    @(negedge clk);
    fs  = 4'b0;
    model_frame(0);
    repeat (2) @(negedge clk);
    fs  = 4'b0001;
    @(negedge clk);
    fs  = 4'b0;
    movr[0] = 1;
    repeat (12) @(negedge clk);
    chk("overrun set", int'(d_ovr), 1);
    check_all("overrun");

    // run falling mid-sequence still completes
    @(negedge clk);
    run = 1'b1;
    fs  = 4'b1111;
    @(negedge clk);
    fs  = 4'b0;
    for (int k = 0; k < 4; k++) model_frame(k);
    repeat (2) @(negedge clk);
    run = 1'b0;
    repeat (12) @(negedge clk);
    check_all("run drop");

    // Async reset mid-sequence
    @(negedge clk);
    run = 1'b1;
    fs  = 4'b1111;
    @(negedge clk);
    fs  = 4'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid rst ball0 x", int'(d_x[9:0]), 150);
    chk("mid rst color", int'(d_c), 8'b11100100);
    chk("mid rst busy/done/ovr", int'({d_busy, d_done, d_ovr}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (d_done) done_cnt++;
    end
    chk("mid rst no done", done_cnt, 0);
    check_all("mid rst");

    // Randomised frames against the model
    for (int i = 0; i < 400; i++) begin
      apply_frame($urandom_range(0, 3) != 0, 4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_all($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
